// File: rtl/rr_encoder_8to3_if.sv
// Grant handshake bundle for the round-robin 8-to-3 encoder.
// The slave modport is the arbiter's view; the master modport is the requester/consumer side.
interface rr_encoder_8to3_if;
   logic       en;
   logic [7:0] req;
   logic       grant_ready;
   logic       grant_valid;
   logic [2:0] grant_idx;
   logic [7:0] grant_onehot;

   modport slave (
      input  en,
      input  req,
      input  grant_ready,
      output grant_valid,
      output grant_idx,
      output grant_onehot
   );

   modport master (
      output en,
      output req,
      output grant_ready,
      input  grant_valid,
      input  grant_idx,
      input  grant_onehot
   );
endinterface

// File: rtl/rr_encoder_8to3.sv
// Round-robin arbiter collapsing eight request lines into a registered binary index
// plus one-hot echo, with a valid/ready handshake and a rotating priority pointer.
module rr_encoder_8to3 (
   input  logic               clk,
   input  logic               reset,
   rr_encoder_8to3_if.slave   bus
);

   typedef enum logic {IDLE, GRANT} state_t;

   state_t     state_q;
   logic [2:0] ptr_q;
   logic       valid_q;
   logic [2:0] idx_q;
   logic [7:0] onehot_q;

   logic       found;
   logic [2:0] win_ptr;
   logic [2:0] win_acc;
   logic [2:0] ptr_d;

   // First set request at or after base, wrapping modulo 8.
   function automatic logic [2:0] rr_pick(input logic [2:0] base, input logic [7:0] r);
      logic       hit;
      logic [2:0] pick;
      logic [2:0] cand;
      hit  = 1'b0;
      pick = base;
      for (int i = 0; i < 8; i++) begin
         cand = base + i[2:0];
         if (!hit && r[cand]) begin
            pick = cand;
            hit  = 1'b1;
         end
      end
      return pick;
   endfunction

   // On accept the reload must search from the just-granted index + 1, not the stale ptr_q.
   assign ptr_d   = idx_q + 3'd1;
   assign found   = |bus.req;
   assign win_ptr = rr_pick(ptr_q, bus.req);
   assign win_acc = rr_pick(ptr_d, bus.req);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         ptr_q    <= 3'd0;
         valid_q  <= 1'b0;
         idx_q    <= 3'd0;
         onehot_q <= 8'h00;
      end else begin
         case (state_q)
            IDLE: begin
               if (bus.en && found) begin
                  idx_q    <= win_ptr;
                  onehot_q <= 8'h01 << win_ptr;
                  valid_q  <= 1'b1;
                  state_q  <= GRANT;
               end
            end
            GRANT: begin
               if (bus.grant_ready) begin
                  ptr_q <= ptr_d;
                  if (bus.en && found) begin
                     idx_q    <= win_acc;
                     onehot_q <= 8'h01 << win_acc;
                     valid_q  <= 1'b1;
                  end else begin
                     idx_q    <= 3'd0;
                     onehot_q <= 8'h00;
                     valid_q  <= 1'b0;
                     state_q  <= IDLE;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.grant_valid  = valid_q;
   assign bus.grant_idx    = idx_q;
   assign bus.grant_onehot = onehot_q;

endmodule

// File: tb/tb_rr_encoder_8to3.sv
// Directed scoreboard bench for the round-robin 8-to-3 encoder.
module tb_rr_encoder_8to3;

   typedef struct {
      string      tag;
      logic       v;
      logic [2:0] idx;
      logic [7:0] oh;
   } exp_t;

   logic clk;
   logic reset;
   int   total;
   int   bad;
   exp_t sb[$];

   rr_encoder_8to3_if bus ();

   rr_encoder_8to3 dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_out();
      exp_t e;
      if (sb.size() == 0) begin
         total++;
         bad++;
         $error("FAIL scoreboard_empty observed=none expected=entry");
         return;
      end
      e = sb.pop_front();
      total++;
      assert (bus.grant_valid === e.v) else begin
         bad++;
         $error("FAIL %s.valid observed=%0b expected=%0b", e.tag, bus.grant_valid, e.v);
      end
      total++;
      assert (bus.grant_onehot === e.oh) else begin
         bad++;
         $error("FAIL %s.onehot observed=%02h expected=%02h", e.tag, bus.grant_onehot, e.oh);
      end
      if (e.v || e.tag == "reset") begin
         total++;
         assert (bus.grant_idx === e.idx) else begin
            bad++;
            $error("FAIL %s.idx observed=%0d expected=%0d", e.tag, bus.grant_idx, e.idx);
         end
      end
   endtask

   // Drive one cycle of inputs, queue the expected registered result, then compare after the edge.
   task automatic step(input string tag, input logic rst_v, input logic en_v,
                       input logic [7:0] req_v, input logic rdy_v,
                       input logic exp_v, input logic [2:0] exp_idx);
      exp_t e;
      reset           = rst_v;
      bus.en          = en_v;
      bus.req         = req_v;
      bus.grant_ready = rdy_v;
      e.tag = tag;
      e.v   = exp_v;
      e.idx = exp_idx;
      e.oh  = exp_v ? (8'h01 << exp_idx) : 8'h00;
      sb.push_back(e);
      @(posedge clk);
      #1;
      check_out();
   endtask

   initial begin
      total = 0;
      bad   = 0;
      reset = 1'b1;
      bus.en = 1'b0;
      bus.req = 8'h00;
      bus.grant_ready = 1'b0;
      @(posedge clk);
      #1;

      // reset then basic grant
      step("reset",     1, 0, 8'h00, 0, 0, 3'd0);
      step("idle",      0, 1, 8'h00, 0, 0, 3'd0);
      step("basic",     0, 1, 8'h10, 0, 1, 3'd4);
      step("basic_acc", 0, 1, 8'h00, 1, 0, 3'd0);

      // back-pressure hold, ptr = 5
      step("bp0", 0, 1, 8'h06, 0, 1, 3'd1);
      step("bp1", 0, 1, 8'h06, 0, 1, 3'd1);
      step("bp2", 0, 1, 8'h04, 0, 1, 3'd1);
      step("bp3", 0, 1, 8'h04, 0, 1, 3'd1);
      step("bp4", 0, 1, 8'h04, 0, 1, 3'd1);
      step("bp_acc",  0, 1, 8'h04, 1, 1, 3'd2);
      step("bp_done", 0, 1, 8'h00, 1, 0, 3'd0);

      // rotation fairness from ptr = 0
      step("reset", 1, 0, 8'h00, 0, 0, 3'd0);
      for (int i = 0; i < 9; i++) begin
         step("rot", 0, 1, 8'hFF, 1, 1, 3'(i % 8));
      end
      step("rot_done", 0, 1, 8'h00, 1, 0, 3'd0);

      // wrap: ptr = 1 here; grant 6 so ptr becomes 7
      step("w6",     0, 1, 8'h40, 0, 1, 3'd6);
      step("w6_acc", 0, 1, 8'h00, 1, 0, 3'd0);
      step("w7",     0, 1, 8'h81, 0, 1, 3'd7);
      step("w0",     0, 1, 8'h81, 1, 1, 3'd0);
      step("w_done", 0, 1, 8'h00, 1, 0, 3'd0);

      // enable gating, ptr = 1
      step("en_off0", 0, 0, 8'h20, 0, 0, 3'd0);
      step("en_off1", 0, 0, 8'h20, 1, 0, 3'd0);
      step("en_g3",   0, 1, 8'h08, 0, 1, 3'd3);
      step("en_hold", 0, 0, 8'h08, 0, 1, 3'd3);
      step("en_acc",  0, 0, 8'h08, 1, 0, 3'd0);
      step("en_stay", 0, 0, 8'h08, 1, 0, 3'd0);

      // reset mid-grant: ptr = 4, steer to ptr = 3 then grant idx 5
      step("mid_g2",  0, 1, 8'h04, 0, 1, 3'd2);
      step("mid_acc", 0, 1, 8'h00, 1, 0, 3'd0);
      step("mid_g5",  0, 1, 8'h20, 0, 1, 3'd5);
      step("reset",   1, 1, 8'h20, 0, 0, 3'd0);
      step("post_rst",0, 1, 8'h30, 0, 1, 3'd4);
      step("post_hold",0, 1, 8'h30, 0, 1, 3'd4);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
